// File: rtl/gcd_stim_pkg.sv
// Shared types and constants for the GCD stimulus driver: FSM states, LFSR taps,
// counter width and the single-step Galois LFSR next-state function.
package gcd_stim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam int unsigned CNT_W     = 16;

  // Right-shifting Galois step: the bit shifted out folds the tap mask back in.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/gcd_stim_lfsr.sv
// 32-bit Galois LFSR that advances two steps per enabled cycle and exposes both
// intermediate next values so one operand pair can be drawn per cycle.
module gcd_stim_lfsr
  import gcd_stim_pkg::*;
#(
  parameter logic [31:0] SEED_P = 32'hACE1_2468
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        adv2_i,
  output logic [31:0] next1_o,
  output logic [31:0] next2_o
);

  logic [31:0] state_r;

  always_comb begin
    next1_o = lfsr_step(state_r);
    next2_o = lfsr_step(next1_o);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= SEED_P;
    end else if (adv2_i) begin
      state_r <= next2_o;
    end
  end

endmodule

// File: rtl/gcd_stim_driver.sv
// Self-running stimulus master for the GCD unit: one request in flight at a time,
// NUM_P pseudo-random operand pairs per run. Optional result checker: GCD_STIM_CHECK_EN.
module gcd_stim_driver
  import gcd_stim_pkg::*;
#(
  parameter int unsigned WIDTH_P = 32,
  parameter int unsigned NUM_P   = 16,
  parameter logic [31:0] SEED_P  = 32'hACE1_2468
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*WIDTH_P-1:0] data_o,
  output logic                 v_o,
  input  logic                 ready_i,
  input  logic [2*WIDTH_P-1:0] data_i,
  input  logic                 v_i,
  output logic                 yumi_o,
  output logic [CNT_W-1:0]     sent_count_o,
  output logic [CNT_W-1:0]     recv_count_o,
`ifdef GCD_STIM_CHECK_EN
  output logic                 error_o,
  output logic [7:0]           err_count_o,
`endif
  output logic [WIDTH_P-1:0]   last_result_o
);

  localparam logic [WIDTH_P-1:0] OP_ONE   = WIDTH_P'(1);
  localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'(NUM_P - 1);

  state_e               state_r;
  logic [WIDTH_P-1:0]   a_r, b_r;
  logic [WIDTH_P-1:0]   a_new, b_new, result;
  logic [31:0]          lfsr_next1, lfsr_next2;
  logic                 start_ok, take, take_last, load_pair;

  always_comb begin
    start_ok  = start_i && (state_r == ST_IDLE || state_r == ST_DONE);
    take      = (state_r == ST_WAIT) && v_i;
    take_last = take && (recv_count_o == LAST_IDX);
    load_pair = start_ok || (take && !take_last);
    result    = data_i[WIDTH_P-1:0];
    a_new     = (lfsr_next1[WIDTH_P-1:0] == '0) ? OP_ONE : lfsr_next1[WIDTH_P-1:0];
    b_new     = (lfsr_next2[WIDTH_P-1:0] == '0) ? OP_ONE : lfsr_next2[WIDTH_P-1:0];
  end

  gcd_stim_lfsr #(
    .SEED_P (SEED_P)
  ) u_lfsr (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .adv2_i    (load_pair),
    .next1_o   (lfsr_next1),
    .next2_o   (lfsr_next2)
  );

  assign v_o    = (state_r == ST_SEND);
  assign yumi_o = take;
  assign busy_o = (state_r == ST_SEND) || (state_r == ST_WAIT);
  assign done_o = (state_r == ST_DONE);
  assign data_o = {a_r, b_r};

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r       <= ST_IDLE;
      a_r           <= '0;
      b_r           <= '0;
      sent_count_o  <= '0;
      recv_count_o  <= '0;
      last_result_o <= '0;
    end else begin
      if (load_pair) begin
        a_r <= a_new;
        b_r <= b_new;
      end
      unique case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state_r      <= ST_SEND;
            sent_count_o <= '0;
            recv_count_o <= '0;
          end
        end
        ST_SEND: begin
          if (ready_i) begin
            sent_count_o <= sent_count_o + 16'd1;
            state_r      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (v_i) begin
            last_result_o <= result;
            recv_count_o  <= recv_count_o + 16'd1;
            state_r       <= take_last ? ST_DONE : ST_SEND;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

`ifdef GCD_STIM_CHECK_EN
  logic fail;

  // a_r/b_r still hold the operands of the request this result answers.
  always_comb begin
    fail = (result == '0) || (result > a_r) || (result > b_r) ||
           (data_i[2*WIDTH_P-1:WIDTH_P] != '0);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      error_o     <= 1'b0;
      err_count_o <= '0;
    end else if (start_ok) begin
      error_o     <= 1'b0;
      err_count_o <= '0;
    end else if (take && fail) begin
      error_o <= 1'b1;
      if (err_count_o != 8'hFF) err_count_o <= err_count_o + 8'd1;
    end
  end
`else
  logic unused_data_hi;
  assign unused_data_hi = ^data_i[2*WIDTH_P-1:WIDTH_P];
`endif

endmodule

// File: tb/tb_gcd_stim_driver.sv
// Self-checking bench for gcd_stim_driver: a behavioural GCD responder and an
// operand-sequence reference model drive and check randomized runs.
module tb_gcd_stim_driver;

  localparam int unsigned W    = 16;
  localparam int unsigned NUM  = 2;
  localparam logic [31:0] SEED = 32'hACE1_2468;
  localparam logic [31:0] TAPS = 32'h8020_0003;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start_i = 1'b0;
  logic             busy_o, done_o, v_o, yumi_o;
  logic [2*W-1:0]   data_o;
  logic             ready_i = 1'b0;
  logic [2*W-1:0]   data_i = '0;
  logic             v_i = 1'b0;
  logic [15:0]      sent_count_o, recv_count_o;
  logic [W-1:0]     last_result_o;
`ifdef GCD_STIM_CHECK_EN
  logic             error_o;
  logic [7:0]       err_count_o;
`endif

  int tests = 0;
  int fails = 0;
  logic [31:0]    m_lfsr;
  logic [2*W-1:0] first_pair;

  always #5 clk = ~clk;

  gcd_stim_driver #(
    .WIDTH_P (W),
    .NUM_P   (NUM),
    .SEED_P  (SEED)
  ) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .start_i       (start_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .data_o        (data_o),
    .v_o           (v_o),
    .ready_i       (ready_i),
    .data_i        (data_i),
    .v_i           (v_i),
    .yumi_o        (yumi_o),
    .sent_count_o  (sent_count_o),
    .recv_count_o  (recv_count_o),
`ifdef GCD_STIM_CHECK_EN
    .error_o       (error_o),
    .err_count_o   (err_count_o),
`endif
    .last_result_o (last_result_o)
  );

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned x = a, y = b, t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x[W-1:0];
  endfunction

  // Next operand pair of the reference sequence: two LFSR steps, zero mapped to 1.
  task automatic model_pair(output logic [2*W-1:0] p);
    logic [W-1:0] a, b;
    m_lfsr = (m_lfsr >> 1) ^ ((m_lfsr % 2 == 1) ? TAPS : 32'h0);
    a = m_lfsr[W-1:0];
    if (a == 0) a = 1;
    m_lfsr = (m_lfsr >> 1) ^ ((m_lfsr % 2 == 1) ? TAPS : 32'h0);
    b = m_lfsr[W-1:0];
    if (b == 0) b = 1;
    p = {a, b};
  endtask

  task automatic start_run();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Plays the GCD side of one transaction; mode 0 = correct gcd, 1 = zero, 2 = a+1.
  task automatic txn(input int rdy_dly, input int lat, input int mode, input bit pulse_start,
                     output logic [2*W-1:0] req, output bit stable, output bit v_after,
                     output bit yumi_seen, output bit to);
    int n = 0;
    stable = 1'b1; v_after = 1'b1; yumi_seen = 1'b0; to = 1'b0; req = '0;
    while (v_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (v_o !== 1'b1) begin
      to = 1'b1;
      return;
    end
    req = data_o;
    for (int i = 0; i < rdy_dly; i++) begin
      ready_i = 1'b0;
      @(negedge clk);
      if (data_o !== req || v_o !== 1'b1) stable = 1'b0;
    end
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    v_after = v_o;
    if (pulse_start) start_run();
    repeat (lat) @(negedge clk);
    case (mode)
      1:       data_i = '0;
      2:       data_i = {{W{1'b0}}, req[2*W-1:W] + W'(1)};
      default: data_i = {{W{1'b0}}, gcd_ref(req[2*W-1:W], req[W-1:0])};
    endcase
    v_i = 1'b1;
    #1;
    yumi_seen = yumi_o;
    @(negedge clk);
    v_i = 1'b0;
    data_i = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    m_lfsr = SEED;
    repeat (2) @(negedge clk);
    tests++;
    if ({v_o, yumi_o, busy_o, done_o} !== 4'b0 || sent_count_o !== 0 || recv_count_o !== 0 ||
        last_result_o !== 0 || data_o !== 0) begin
      fails++;
      $display("FAIL reset_outputs: got v=%b yumi=%b busy=%b done=%b sent=%0d recv=%0d last=%h data=%h, expected all 0",
               v_o, yumi_o, busy_o, done_o, sent_count_o, recv_count_o, last_result_o, data_o);
    end
`ifdef GCD_STIM_CHECK_EN
    tests++;
    if (error_o !== 1'b0 || err_count_o !== 8'd0) begin
      fails++;
      $display("FAIL reset_err: got error=%b cnt=%0d, expected 0/0", error_o, err_count_o);
    end
`endif
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      v_i = (i == 4);
      @(negedge clk);
      tests++;
      if (v_o !== 1'b0 || busy_o !== 1'b0 || yumi_o !== 1'b0) begin
        fails++;
        $display("FAIL idle_quiet[%0d]: got v=%b busy=%b yumi=%b, expected 0/0/0", i, v_o, busy_o, yumi_o);
      end
    end
    v_i = 1'b0;
  endtask

  task automatic test_basic();
    logic [2*W-1:0] exp, req;
    bit stable, v_after, yumi_seen, to;
    start_run();
    tests++;
    if (busy_o !== 1'b1 || v_o !== 1'b1 || sent_count_o !== 0 || recv_count_o !== 0) begin
      fails++;
      $display("FAIL start_state: got busy=%b v=%b sent=%0d recv=%0d, expected 1/1/0/0",
               busy_o, v_o, sent_count_o, recv_count_o);
    end
    for (int i = 0; i < NUM; i++) begin
      model_pair(exp);
      if (i == 0) first_pair = exp;
      txn($urandom_range(0, 2), 3, 0, 1'b0, req, stable, v_after, yumi_seen, to);
      tests++;
      if (to || req !== exp || v_after !== 1'b0 || yumi_seen !== 1'b1) begin
        fails++;
        $display("FAIL basic_txn[%0d]: got req=%h v_after=%b yumi=%b timeout=%b, expected req=%h 0 1 0",
                 i, req, v_after, yumi_seen, to, exp);
      end
      tests++;
      if (sent_count_o !== 16'(i + 1) || recv_count_o !== 16'(i + 1) ||
          v_o !== (i < NUM - 1)) begin
        fails++;
        $display("FAIL basic_counts[%0d]: got sent=%0d recv=%0d v=%b, expected %0d %0d %b",
                 i, sent_count_o, recv_count_o, v_o, i + 1, i + 1, i < NUM - 1);
      end
    end
    tests++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || last_result_o !== gcd_ref(exp[2*W-1:W], exp[W-1:0])) begin
      fails++;
      $display("FAIL basic_done: got done=%b busy=%b last=%h, expected 1 0 %h",
               done_o, busy_o, last_result_o, gcd_ref(exp[2*W-1:W], exp[W-1:0]));
    end
    repeat (3) @(negedge clk);
    tests++;
    if (done_o !== 1'b1 || v_o !== 1'b0) begin
      fails++;
      $display("FAIL done_hold: got done=%b v=%b, expected 1 0", done_o, v_o);
    end
  endtask

  task automatic test_ready_stall();
    logic [2*W-1:0] exp, req;
    bit stable, v_after, yumi_seen, to;
    start_run();
    model_pair(exp);
    txn(5, $urandom_range(1, 4), 0, 1'b0, req, stable, v_after, yumi_seen, to);
    tests++;
    if (to || !stable || req !== exp || sent_count_o !== 16'd1) begin
      fails++;
      $display("FAIL stall_txn: got req=%h stable=%b sent=%0d timeout=%b, expected req=%h stable=1 sent=1",
               req, stable, sent_count_o, to, exp);
    end
    model_pair(exp);
    txn(0, $urandom_range(1, 4), 0, 1'b0, req, stable, v_after, yumi_seen, to);
    tests++;
    if (to || req !== exp || done_o !== 1'b1 || sent_count_o !== 16'd2) begin
      fails++;
      $display("FAIL stall_second: got req=%h done=%b sent=%0d, expected req=%h done=1 sent=2",
               req, done_o, sent_count_o, exp);
    end
  endtask

  task automatic test_start_in_wait();
    logic [2*W-1:0] exp, req;
    bit stable, v_after, yumi_seen, to;
    start_run();
    model_pair(exp);
    txn(1, 3, 0, 1'b1, req, stable, v_after, yumi_seen, to);
    tests++;
    if (to || req !== exp || sent_count_o !== 16'd1 || recv_count_o !== 16'd1 || busy_o !== 1'b1) begin
      fails++;
      $display("FAIL wait_start_first: got req=%h sent=%0d recv=%0d busy=%b, expected req=%h 1 1 1",
               req, sent_count_o, recv_count_o, busy_o, exp);
    end
    model_pair(exp);
    txn(0, 2, 0, 1'b0, req, stable, v_after, yumi_seen, to);
    tests++;
    if (to || req !== exp || done_o !== 1'b1 || recv_count_o !== 16'd2) begin
      fails++;
      $display("FAIL wait_start_done: got req=%h done=%b recv=%0d, expected req=%h 1 2",
               req, done_o, recv_count_o, exp);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [2*W-1:0] exp, req;
    bit stable, v_after, yumi_seen, to;
    start_run();
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    tests++;
    if (busy_o !== 1'b1 || v_o !== 1'b0) begin
      fails++;
      $display("FAIL mid_wait_state: got busy=%b v=%b, expected 1 0", busy_o, v_o);
    end
    reset_n = 1'b0;
    v_i = 1'b1;
    #1;
    tests++;
    if (busy_o !== 1'b0 || yumi_o !== 1'b0 || sent_count_o !== 0 || data_o !== 0 || last_result_o !== 0) begin
      fails++;
      $display("FAIL mid_reset: got busy=%b yumi=%b sent=%0d data=%h last=%h, expected all 0",
               busy_o, yumi_o, sent_count_o, data_o, last_result_o);
    end
    v_i = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    m_lfsr = SEED;
    @(negedge clk);
    start_run();
    model_pair(exp);
    txn(0, 2, 0, 1'b0, req, stable, v_after, yumi_seen, to);
    tests++;
    if (to || req !== first_pair || req !== exp) begin
      fails++;
      $display("FAIL reseed_pair: got req=%h, expected %h", req, first_pair);
    end
    model_pair(exp);
    txn(0, 2, 0, 1'b0, req, stable, v_after, yumi_seen, to);
    tests++;
    if (to || req !== exp || done_o !== 1'b1) begin
      fails++;
      $display("FAIL reseed_second: got req=%h done=%b, expected %h 1", req, done_o, exp);
    end
  endtask

  task automatic test_random_runs();
    logic [2*W-1:0] exp, req;
    bit stable, v_after, yumi_seen, to;
    for (int r = 0; r < 6; r++) begin
      start_run();
      for (int i = 0; i < NUM; i++) begin
        model_pair(exp);
        txn($urandom_range(0, 4), $urandom_range(0, 6), 0, 1'b0, req, stable, v_after, yumi_seen, to);
        tests++;
        if (to || !stable || req !== exp || yumi_seen !== 1'b1 ||
            last_result_o !== gcd_ref(exp[2*W-1:W], exp[W-1:0])) begin
          fails++;
          $display("FAIL random[%0d.%0d]: got req=%h stable=%b yumi=%b last=%h, expected req=%h last=%h",
                   r, i, req, stable, yumi_seen, last_result_o, exp, gcd_ref(exp[2*W-1:W], exp[W-1:0]));
        end
      end
      tests++;
      if (done_o !== 1'b1 || sent_count_o !== 16'(NUM) || recv_count_o !== 16'(NUM)) begin
        fails++;
        $display("FAIL random_done[%0d]: got done=%b sent=%0d recv=%0d, expected 1 %0d %0d",
                 r, done_o, sent_count_o, recv_count_o, NUM, NUM);
      end
    end
  endtask

`ifdef GCD_STIM_CHECK_EN
  task automatic test_checker();
    logic [2*W-1:0] exp, req;
    bit stable, v_after, yumi_seen, to;
    start_run();
    model_pair(exp);
    txn(0, 2, 1, 1'b0, req, stable, v_after, yumi_seen, to);
    model_pair(exp);
    txn(0, 2, 2, 1'b0, req, stable, v_after, yumi_seen, to);
    tests++;
    if (to || error_o !== 1'b1 || err_count_o !== 8'd2) begin
      fails++;
      $display("FAIL check_errors: got error=%b cnt=%0d, expected 1 2", error_o, err_count_o);
    end
    start_run();
    tests++;
    if (error_o !== 1'b0 || err_count_o !== 8'd0) begin
      fails++;
      $display("FAIL check_clear: got error=%b cnt=%0d, expected 0 0", error_o, err_count_o);
    end
    for (int i = 0; i < NUM; i++) begin
      model_pair(exp);
      txn(0, 1, 0, 1'b0, req, stable, v_after, yumi_seen, to);
    end
    tests++;
    if (to || error_o !== 1'b0 || err_count_o !== 8'd0 || done_o !== 1'b1) begin
      fails++;
      $display("FAIL check_good_run: got error=%b cnt=%0d done=%b, expected 0 0 1",
               error_o, err_count_o, done_o);
    end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_ready_stall();
    test_start_in_wait();
    test_random_runs();
    test_reset_mid_wait();
`ifdef GCD_STIM_CHECK_EN
    test_checker();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gcd_stim_driver.md
# gcd_stim_driver

Self-running stimulus master for the GCD unit, driving the other end of its streaming interfaces. It generates pseudo-random operand pairs, presents them on the GCD input channel (valid/ready), accepts each result on the GCD output channel (valid/yumi), and counts transactions. It sits beside `gcd` in the clock-gated/downsampled test harness, clocked by the same generated clock, so a GCD run needs no external stimulus beyond `start_i`.

## Interface
- `WIDTH_P`, 32: operand width, 1..32.
- `NUM_P`, 16: transactions per run, 1..65535.
- `SEED_P`, 32'hACE1_2468: LFSR reset value; must be nonzero.

Ports:
- `clk_i`  in  1  clock; the generated clock from the harness.
- `reset_n_i`  in  1  reset; asynchronous, active-low.
- `start_i`  in  1  begins a run; honoured only in IDLE or DONE.
- `busy_o`  out  1  high in SEND or WAIT.
- `done_o`  out  1  high in DONE.
- `data_o`  out  2*WIDTH_P  request payload: {a, b}, with a in the upper half.
- `v_o`  out  1  request valid.
- `ready_i`  in  1  GCD ready to accept a request.
- `data_i`  in  2*WIDTH_P  result; the gcd is in `data_i[WIDTH_P-1:0]`.
- `v_i`  in  1  result valid.
- `yumi_o`  out  1  result consumed this cycle.
- `sent_count_o`  out  16  requests transferred in the current run.
- `recv_count_o`  out  16  results accepted in the current run.
- `last_result_o`  out  WIDTH_P  most recently accepted gcd value.
- `error_o`  out  1  sticky check failure; present only under the configuration macro.
- `err_count_o`  out  8  saturating failure count; present only under the configuration macro.

## Operation
- FSM states: IDLE, SEND, WAIT, DONE.
- IDLE/DONE -> SEND on `start_i`:
  - clear both counters, `error_o`, and `err_count_o`;
  - latch operands a and b from the LFSR.
- SEND:
  - `v_o`=1 with `data_o` = {a, b} held stable;
  - on `v_o & ready_i`: `sent_count_o`++, then -> WAIT.
- WAIT:
  - `yumi_o` = `v_i`, combinational, WAIT only;
  - on `v_i`: `last_result_o` <= `data_i[WIDTH_P-1:0]` and `recv_count_o`++;
  - then -> DONE if `recv_count_o` reaches `NUM_P`, else -> SEND with a new operand pair latched.
- Exactly one request is in flight at a time; a and b are held in registers until their result is accepted.
- Operand generation:
  - 32-bit Galois LFSR, tap mask 32'h8020_0003.
  - a = `lfsr[WIDTH_P-1:0]` after step 1; b = the same slice after step 2.
  - The LFSR steps twice per pair, using two chained next-state functions in one cycle.
  - A zero operand is replaced by 1.
- The LFSR is not reseeded between runs, so successive runs differ. Only reset restores `SEED_P`.
- `v_i` outside WAIT is ignored, with `yumi_o`=0.
- `start_i` in SEND or WAIT is ignored.

## Timing
- Reset values (async, `reset_n_i`=0):
  - state IDLE, LFSR = `SEED_P`;
  - all outputs 0: `v_o`, `yumi_o`, `busy_o`, `done_o`, counters, `last_result_o`, `data_o`, `error_o`, `err_count_o`.
- `start_i` sampled high at edge N -> `v_o`=1 from edge N onward.
- Request handshake: the transfer occurs on the edge where `v_o & ready_i`. `v_o` deasserts after that edge.
- Result handshake: `yumi_o` is asserted in the same cycle `v_i` is seen; the result is consumed on that edge.
- Next request: after the result edge at M, the next `v_o` is high from edge M. Minimum request-to-request spacing = GCD latency + 1 cycle.
- DONE: `done_o` is high the cycle after the final result edge and holds until `start_i` or reset.
- Reset mid-run: immediate return to IDLE with the reset values above. An in-flight result is abandoned; the GCD must also be reset.
- `ready_i` low for any number of cycles: `data_o` and `v_o` are held unchanged.

## Configuration
- Macro `GCD_STIM_CHECK_EN`.
- Defined: checker on each accepted result r. A failure is any of:
  - r==0;
  - r>a or r>b;
  - `data_i[2*WIDTH_P-1:WIDTH_P]` != 0.
- Defined, on failure: `error_o` is set (sticky) and `err_count_o` increments, saturating at 255.
- Undefined: the `error_o` and `err_count_o` ports and the checker logic are absent.

## Structure
- Package `gcd_stim_pkg`:
  - state enum;
  - LFSR tap mask constant 32'h8020_0003;
  - counter width constant 16.
- Sub-module `gcd_stim_lfsr`: 32-bit Galois LFSR with seed parameter, an advance-by-two enable, and two next-value outputs.

## Test plan
- Reset, then release: all outputs 0; state IDLE; no `v_o` for 10 cycles without `start_i`.
- `NUM_P`=2 with an ideal responder (ready=1, correct gcd after 3 cycles): 2 transfers; `sent_count_o`=`recv_count_o`=2; `done_o`=1; `last_result_o` = gcd of the second pair.
- `ready_i` held low 5 cycles during SEND: `data_o` stable all 5 cycles; a single transfer when `ready_i` rises.
- `GCD_STIM_CHECK_EN` defined; responder returns 0, then a + 1: `error_o`=1; `err_count_o`=2; the next `start_i` clears both.
- `start_i` pulsed during WAIT: no effect; counters continue; run completes normally.
- Reset asserted mid-WAIT, then a new start: the first pair equals the first pair of the power-on run.
